// File: rtl/spm_feeder.sv
// Operand feeder and product collector for a serial-parallel (CSA chain) multiplier.
// Presents x in parallel, streams y LSB first with sign extension, and gathers p into prod.
module spm_feeder #(
    parameter int SIZE = 32,
    parameter int LAT  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SIZE-1:0]     a,
    input  logic [SIZE-1:0]     b,
    output logic [SIZE-1:0]     x,
    output logic                y,
    output logic                clr,
    input  logic                p,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*SIZE-1:0]   prod
);

    localparam int RUN_LEN = 2 * SIZE + LAT;
    localparam int CNT_W   = $clog2(RUN_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_LEN - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SIZE-1:0]     x_q, x_d;
    logic [SIZE-1:0]     bsh_q, bsh_d;
    logic [2*SIZE-1:0]   prod_q, prod_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            bsh_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            bsh_q   <= bsh_d;
            prod_q  <= prod_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        bsh_d     = bsh_q;
        prod_d    = prod_q;
        in_ready  = 1'b0;
        clr       = 1'b0;
        y         = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    x_d     = a;
                    bsh_d   = b;
                    prod_d  = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                clr     = 1'b1;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                // Arithmetic shift: once the multiplier is exhausted, bit 0 keeps repeating its sign.
                y     = bsh_q[0];
                bsh_d = {bsh_q[SIZE-1], bsh_q[SIZE-1:1]};
                if (int'(cnt_q) >= LAT) begin
                    prod_d = {p, prod_q[2*SIZE-1:1]};
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign x    = x_q;
    assign prod = prod_q;

endmodule

// File: doc/spm_feeder.md
SPM_FEEDER -- requirements
Module: spm_feeder

Interface
REQ-001 The block SHALL have parameter SIZE, default 32, giving the operand width in bits; legal range is 2..64.
REQ-002 The block SHALL have parameter LAT, default 0, giving the cycles between driving y bit k and the matching product bit k on p.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port in_valid, input, 1 bit: operand pair a/b is offered.
REQ-006 Port in_ready, output, 1 bit: the block accepts an operand pair.
REQ-007 Port a, input, SIZE bits: multiplicand, two's complement.
REQ-008 Port b, input, SIZE bits: multiplier, two's complement.
REQ-009 Port x, output, SIZE bits: parallel multiplicand driven to the CSA chain.
REQ-010 Port y, output, 1 bit: serial multiplier bit driven to the CSA chain.
REQ-011 Port clr, output, 1 bit: synchronous clear pulse to the CSA chain registers.
REQ-012 Port p, input, 1 bit: serial product bit from the chain, LSB first.
REQ-013 Port out_valid, output, 1 bit: the product is available.
REQ-014 Port out_ready, input, 1 bit: the consumer accepts the product.
REQ-015 Port prod, output, 2*SIZE bits: full signed product.

Function
REQ-016 The FSM SHALL have the states IDLE, CLEAR, RUN and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE.
REQ-018 An operand pair is accepted when in_valid and in_ready are both 1; at that edge a SHALL be latched into the x register, b SHALL be latched into the shift register, and the FSM SHALL go to CLEAR.
REQ-019 clr SHALL be 1 for exactly the one cycle spent in CLEAR; y SHALL be 0 in CLEAR; the next state SHALL be RUN.
REQ-020 RUN SHALL last exactly 2*SIZE+LAT cycles, counted by cnt, which SHALL be 0 on the first RUN cycle.
REQ-021 For cnt < SIZE, y SHALL be b[cnt], which makes the multiplier LSB first.
REQ-022 For SIZE <= cnt < 2*SIZE+LAT, y SHALL be b[SIZE-1], the sign extension.
REQ-023 For LAT <= cnt < 2*SIZE+LAT, the p bit sampled on that cycle's clock edge SHALL be shifted into the product register from the MSB side, as prod <= {p, prod[2*SIZE-1:1]}.
REQ-024 After the last RUN cycle the FSM SHALL go to DONE and set out_valid to 1.
REQ-025 In DONE, prod SHALL be held stable, and so SHALL out_valid, until out_ready is 1.
REQ-026 The edge with out_valid and out_ready both 1 SHALL clear out_valid and return the FSM to IDLE.
REQ-027 A new operand SHALL NOT be accepted in the same cycle as the DONE handshake.
REQ-028 Minimum throughput is one product per 2*SIZE+LAT+3 cycles.
REQ-029 x SHALL remain constant from the accept edge until the next accept edge.
REQ-030 y SHALL be 0 in IDLE and DONE.
REQ-031 in_valid in any state other than IDLE SHALL be ignored, and the operands SHALL NOT change.
REQ-032 out_ready outside DONE SHALL have no effect.
REQ-033 The cnt width SHALL be $clog2(2*SIZE+LAT+1); the counter SHALL NOT wrap within one operation.
REQ-034 prod SHALL equal the product a*b taken modulo 2^(2*SIZE), interpreted as signed, provided the chain is a correct serial-parallel multiplier.

Reset
REQ-035 When rst=0, asynchronously and regardless of clk, the following SHALL hold: FSM=IDLE, cnt=0, x=0, b shift register=0, prod=0, y=0, clr=0, out_valid=0, in_ready=1.
REQ-036 A reset asserted during CLEAR, RUN or DONE SHALL abort the operation; no partial product SHALL be presented afterwards.
REQ-037 After rst is released, the first clock edge SHALL be able to accept an operand pair.

Verification
REQ-038 The bench SHALL cover these directed scenarios, each with SIZE=32, LAT=0 and a behavioural spm chain model:
- Accept a=3, b=5 -> clr high for 1 cycle, 64 RUN cycles, out_valid on cycle 66 after accept, prod=0x000000000000000F.
- a=-2, b=7 -> prod=0xFFFFFFFFFFFFFFF2; y=0 for cycles 32..63.
- a=0x80000000, b=0x80000000 -> prod=0x4000000000000000.
- out_ready held 0 for 10 cycles in DONE -> prod and out_valid stable; in_ready=0 throughout; on release, return to IDLE in 1 cycle.
- rst pulsed low at RUN cycle 20 -> all outputs at reset values immediately; the next operation a=1, b=1 gives prod=1.
- LAT=2 build, a=-1, b=-1 -> RUN lasts 66 cycles, prod=1.
